pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/adder_pkg.sv | 12 +
 rtl/adder_slice.sv | 26 ++
 rtl/pipelined_adder.sv | 116 +++++++++++
 tb/tb_pipelined_adder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the slice-pipelined adder: slice width and
// the add/subtract mode encoding.
package adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } op_e;

endpackage

// File: rtl/adder_slice.sv
// Combinational 4-bit adder slice. Exposes the carry into its top bit
// (c3) so the final stage can form signed overflow.
module adder_slice
    import adder_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               c3
);

    logic [SLICE_W-1:0] lo;
    logic [1:0]         hi;

    // Low bits are added separately so the carry into the top bit is visible.
    assign lo = {1'b0, x[SLICE_W-2:0]} + {1'b0, y[SLICE_W-2:0]}
              + {{(SLICE_W-1){1'b0}}, cin};
    assign c3 = lo[SLICE_W-1];
    assign hi = {1'b0, x[SLICE_W-1]} + {1'b0, y[SLICE_W-1]} + {1'b0, c3};

    assign sum  = {hi[0], lo[SLICE_W-2:0]};
    assign cout = hi[1];

endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract pipelined one 4-bit slice per stage with valid/ready
// handshaking; the whole pipeline stalls when the output is blocked.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   s,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SLICE_W;

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             ovf_q;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign b_eff    = (op_e'(sub) == SUB) ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : stage
        localparam int RW = SLICE_W * (k + 1);   // result bits completed so far
        localparam int AW = WIDTH - RW;          // operand bits still to add

        logic [SLICE_W-1:0] x, y, sum;
        logic               cin, vin, cout, c3;
        logic [RW-1:0]      res_d;
        logic               valid_q, carry_q;
        logic [RW-1:0]      res_q;

        if (k == 0) begin : g_first
            assign x     = a[SLICE_W-1:0];
            assign y     = b_eff[SLICE_W-1:0];
            assign cin   = sub;
            assign vin   = in_valid;
            assign res_d = sum;
        end else begin : g_next
            assign x     = stage[k-1].g_rem.opa_q[SLICE_W-1:0];
            assign y     = stage[k-1].g_rem.opb_q[SLICE_W-1:0];
            assign cin   = stage[k-1].carry_q;
            assign vin   = stage[k-1].valid_q;
            assign res_d = {sum, stage[k-1].res_q};
        end

        adder_slice u_slice (
            .x    (x),
            .y    (y),
            .cin  (cin),
            .sum  (sum),
            .cout (cout),
            .c3   (c3)
        );

        // NOTE: sequential state uses non-blocking assignments so every stage
        // samples its predecessor's pre-edge value, independent of block order.
        // NOTE: the datapath is reset along with the valid bits so no stale
        // operand or carry survives a reset into later cycles.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                res_q   <= '0;
            end else if (en) begin
                valid_q <= vin;
                carry_q <= cout;
                res_q   <= res_d;
            end
        end

        // Upper operand bits ride along until their slice is reached.
        if (AW > 0) begin : g_rem
            logic [AW-1:0] opa_d, opb_d, opa_q, opb_q;

            if (k == 0) begin : g_src
                assign opa_d = a[WIDTH-1:SLICE_W];
                assign opb_d = b_eff[WIDTH-1:SLICE_W];
            end else begin : g_src
                assign opa_d = stage[k-1].g_rem.opa_q[AW+SLICE_W-1:SLICE_W];
                assign opb_d = stage[k-1].g_rem.opb_q[AW+SLICE_W-1:SLICE_W];
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else if (en) begin
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= stage[STAGES-1].c3 ^ stage[STAGES-1].cout;
        end
    end

    assign out_valid = stage[STAGES-1].valid_q;
    assign s         = {stage[STAGES-1].carry_q, stage[STAGES-1].res_q};
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=8): directed vectors push
// expected results; an independent monitor pops and compares on output transfers.
module tb_pipelined_adder;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH:0] s;
        logic           ovf;
        int             t;
        bit             chk_lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   s;
    logic             ovf;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;

    pipelined_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Offer one operation; expectation is queued on the cycle the DUT accepts it.
    task automatic send(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic isub,
                        input logic [WIDTH:0] es, input logic eo, input bit lat);
        bit accepted = 1'b0;
        @(posedge clk); #1;
        a = ia; b = ib; sub = isub; in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (rst_n && in_ready) begin
                sb.push_back('{s: es, ovf: eo, t: cyc, chk_lat: lat});
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    // Monitor: every output transfer must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", {23'd0, s}, 32'hDEAD);
                end else begin
                    e = sb.pop_front();
                    check("s", {23'd0, s}, {23'd0, e.s});
                    check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                    if (e.chk_lat) check("latency", cyc - e.t, 32'd2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_s", {23'd0, s}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed arithmetic vectors, unstalled
        send(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0, 1'b1);
        idle(3);
        send(8'h05, 8'h07, 1'b1, 9'h0FE, 1'b0, 1'b1);
        send(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, 1'b1);
        send(8'h80, 8'h01, 1'b1, 9'h17F, 1'b1, 1'b1);
        send(8'h80, 8'h80, 1'b0, 9'h100, 1'b1, 1'b1);
        send(8'h00, 8'h00, 1'b1, 9'h100, 1'b0, 1'b1);
        send(8'h0F, 8'h01, 1'b0, 9'h010, 1'b0, 1'b1);
        send(8'h01, 8'h02, 1'b1, 9'h0FF, 1'b0, 1'b1);
        idle(3);

        // Back-to-back i+i: latency check on every result implies one per cycle
        for (int i = 0; i < 10; i++)
            send(8'(i), 8'(i), 1'b0, 9'(2 * i), 1'b0, 1'b1);
        idle(4);

        // Stall with a result pending: outputs hold, input side blocked
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(8'h0F, 8'h01, 1'b0, 9'h010, 1'b0, 1'b0);
        send(8'h80, 8'h80, 1'b0, 9'h100, 1'b1, 1'b0);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_s", {23'd0, s}, 32'h010);
        end
        // A new operation waits until the stall is released
        fork
            send(8'h01, 8'h01, 1'b0, 9'h002, 1'b0, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(5);

        // Reset with two operations in flight: neither may ever appear
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b0, 9'h033, 1'b0, 1'b0);
        send(8'h40, 8'h40, 1'b0, 9'h080, 1'b1, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_s", {23'd0, s}, 32'd0);
        check("post_rst_ovf", {31'd0, ovf}, 32'd0);
        idle(6);
        send(8'h01, 8'h02, 1'b1, 9'h0FF, 1'b0, 1'b1);
        idle(1);

        // Everything issued must have emerged
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        check("drain", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
